// File: rtl/mbist_pkg.sv
// Shared March C- tables and FSM states for the MBIST sequence generator.
// Per-element tables are bit vectors indexed by march element number.
package mbist_pkg;

   typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

   localparam logic [2:0] LAST_ELEM = 3'd5;

   // bit i describes element Mi: M3/M4 run down, M1..M4 have two ops
   localparam logic [7:0] ELEM_DN  = 8'b0001_1000;
   localparam logic [7:0] ELEM_2OP = 8'b0001_1110;
   localparam logic [7:0] OP0_RD   = 8'b0011_1110;
   localparam logic [7:0] OP0_VAL  = 8'b0001_0100;
   localparam logic [7:0] OP1_VAL  = 8'b0000_1010;

   localparam logic [1:0] CB_BG0 = 2'b01;
   localparam logic [1:0] CB_BG1 = 2'b10;

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter for March C- elements.
// Flags the terminal address of the current sweep direction.
module mbist_addr_gen #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              load_dn,
   input  logic              step,
   input  logic              dn,
   output logic [ADDR_W-1:0] addr,
   output logic              is_last
);

   logic [ADDR_W-1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (load)
         addr_d = load_dn ? '1 : '0;
      else if (step)
         addr_d = dn ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) addr_q <= '0;
      else     addr_q <= addr_d;
   end

   assign addr    = addr_q;
   assign is_last = dn ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mbist_march_counter.sv
// March C- sequence generator: FSM, element/op sequencing, data decode.
// Define MBIST_CHECKERBOARD_EN for a second checkerboard-background pass.
module mbist_march_counter
   import mbist_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] exp_data,
   output logic              we,
   output logic              re,
   output logic [2:0]        elem,
   output logic              cout
);

   state_t     state_q, state_d;
   logic [2:0] elem_q, elem_d;
   logic       op_q, op_d;
   logic       ag_load, ag_load_dn, ag_step;
   logic       addr_last, last_op, is_rd, val;
   logic [2:0] elem_nx;
   logic [DATA_W-1:0] bg0, bg1, bg;

`ifdef MBIST_CHECKERBOARD_EN
   logic pass_q, pass_d;
   assign bg0 = pass_q ? {DATA_W/2{CB_BG0}} : '0;
   assign bg1 = pass_q ? {DATA_W/2{CB_BG1}} : '1;
`else
   assign bg0 = '0;
   assign bg1 = '1;
`endif

   mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
      .clk     (clk),
      .rst     (rst),
      .load    (ag_load),
      .load_dn (ag_load_dn),
      .step    (ag_step),
      .dn      (ELEM_DN[elem_q]),
      .addr    (addr),
      .is_last (addr_last)
   );

   assign elem_nx = elem_q + 3'd1;
   assign last_op = op_q | ~ELEM_2OP[elem_q];

   always_comb begin
      state_d    = state_q;
      elem_d     = elem_q;
      op_d       = op_q;
      ag_load    = 1'b0;
      ag_load_dn = 1'b0;
      ag_step    = 1'b0;
`ifdef MBIST_CHECKERBOARD_EN
      pass_d     = pass_q;
`endif
      if (ld) begin
         state_d = LOAD;
         elem_d  = '0;
         op_d    = 1'b0;
         ag_load = 1'b1;
`ifdef MBIST_CHECKERBOARD_EN
         pass_d  = 1'b0;
`endif
      end else begin
         unique case (state_q)
            LOAD: if (en) state_d = RUN;
            RUN: if (en) begin
               if (!last_op) begin
                  op_d = 1'b1;
               end else begin
                  op_d = 1'b0;
                  if (!addr_last) begin
                     ag_step = 1'b1;
                  end else if (elem_q != LAST_ELEM) begin
                     elem_d     = elem_nx;
                     ag_load    = 1'b1;
                     ag_load_dn = ELEM_DN[elem_nx];
                  end else begin
`ifdef MBIST_CHECKERBOARD_EN
                     if (!pass_q) begin
                        pass_d  = 1'b1;
                        elem_d  = '0;
                        ag_load = 1'b1;
                     end else begin
                        state_d = DONE;
                     end
`else
                     state_d = DONE;
`endif
                  end
               end
            end
            DONE: state_d = DONE;
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LOAD;
         elem_q  <= '0;
         op_q    <= 1'b0;
`ifdef MBIST_CHECKERBOARD_EN
         pass_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         op_q    <= op_d;
`ifdef MBIST_CHECKERBOARD_EN
         pass_q  <= pass_d;
`endif
      end
   end

   assign is_rd = ~op_q & OP0_RD[elem_q];
   assign val   = op_q ? OP1_VAL[elem_q] : OP0_VAL[elem_q];
   assign bg    = val ? bg1 : bg0;

   always_comb begin
      we       = 1'b0;
      re       = 1'b0;
      wdata    = '0;
      exp_data = '0;
      if (state_q == RUN) begin
         re = is_rd;
         we = ~is_rd;
         if (is_rd) exp_data = bg;
         else       wdata    = bg;
      end
   end

   assign elem = elem_q;
   assign cout = (state_q == DONE);

endmodule

// File: tb/tb_mbist_march_counter.sv
// Self-checking bench: directed March C- scenarios plus random ld/en/rst
// traffic against a flat op-list reference model.
module tb_mbist_march_counter;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int DEPTH = 1 << AW;
`ifdef MBIST_CHECKERBOARD_EN
   localparam int NP = 2;
`else
   localparam int NP = 1;
`endif
   localparam int N = NP * 10 * DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b0, ld = 1'b0, en = 1'b0;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, exp_data;
   logic we, re, cout;
   logic [2:0] elem;

   mbist_march_counter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .ld(ld), .en(en),
      .addr(addr), .wdata(wdata), .exp_data(exp_data),
      .we(we), .re(re), .elem(elem), .cout(cout)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic          w;
      logic          r;
      logic [2:0]    e;
      logic [DW-1:0] wd;
      logic [DW-1:0] ex;
   } op_t;

   op_t seq[$];
   int  ms = 0;
   int  idx = 0;
   int  errors = 0;
   int  checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // expand March C- into a flat list of ops
   task automatic build();
      for (int p = 0; p < NP; p++)
         for (int e = 0; e < 6; e++) begin
            int nops;
            bit dn;
            nops = (e == 0 || e == 5) ? 1 : 2;
            dn = (e == 3 || e == 4);
            for (int k = 0; k < DEPTH; k++)
               for (int o = 0; o < nops; o++) begin
                  op_t t;
                  bit v, rd;
                  logic [DW-1:0] b;
                  rd = (e != 0) && (o == 0);
                  if (e == 2 || e == 4) v = (o == 0);
                  else if (e == 1 || e == 3) v = (o == 1);
                  else v = 1'b0;
                  if (p == 0) b = v ? 8'hFF : 8'h00;
                  else        b = v ? 8'hAA : 8'h55;
                  t.a  = dn ? AW'(DEPTH - 1 - k) : AW'(k);
                  t.w  = !rd;
                  t.r  = rd;
                  t.e  = 3'(e);
                  t.wd = rd ? 8'h00 : b;
                  t.ex = rd ? b : 8'h00;
                  seq.push_back(t);
               end
         end
   endtask

   function automatic logic [31:0] want_vec();
      op_t t;
      logic c;
      t = '0;
      c = 1'b0;
      if (ms == 1) begin
         t = seq[idx];
      end else if (ms == 2) begin
         t.a = seq[N-1].a;
         t.e = seq[N-1].e;
         c = 1'b1;
      end
      return 32'({t.a, t.w, t.r, t.e, c, t.wd, t.ex});
   endfunction

   function automatic logic [31:0] got_vec();
      return 32'({addr, we, re, elem, cout, wdata, exp_data});
   endfunction

   task automatic tick(input logic r, input logic l, input logic e);
      rst = r; ld = l; en = e;
      @(posedge clk);
      if (r || l) begin
         ms = 0; idx = 0;
      end else if (e) begin
         if (ms == 0) begin
            ms = 1; idx = 0;
         end else if (ms == 1) begin
            if (idx == N - 1) ms = 2;
            else idx++;
         end
      end
      #1;
      chk("outs", got_vec(), want_vec());
   endtask

   initial begin
      build();
      if (seq.size() != N) $fatal(1, "FAIL build: size %0d want %0d", seq.size(), N);

      tick(1, 0, 0);
      chk("rst_cout", 32'(cout), 0);
      chk("rst_addr", 32'(addr), 0);
      tick(1, 1, 0);
      chk("rst_ld_we_re", 32'({we, re}), 0);

      // full pass with en held high
      for (int k = 1; k <= N + 1; k++) begin
         tick(0, 0, 1);
         if (k == 1) chk("m0_op0", 32'({we, addr, wdata}), 32'({1'b1, 2'd0, 8'h00}));
         if (k == 21) chk("m3_op0", 32'({re, addr, exp_data}), 32'({1'b1, 2'd3, 8'h00}));
         if (k == 29) chk("m4_op0", 32'({re, addr, exp_data}), 32'({1'b1, 2'd3, 8'hFF}));
`ifdef MBIST_CHECKERBOARD_EN
         if (k == 41) chk("p2_m0", 32'({we, addr, wdata}), 32'({1'b1, 2'd0, 8'h55}));
         if (k == 46) chk("p2_m1op1", 32'({we, addr, wdata}), 32'({1'b1, 2'd0, 8'hAA}));
`endif
         if (k == N) chk("cout_early", 32'(cout), 0);
         if (k == N + 1) chk("cout_full", 32'(cout), 1);
      end

      // ld in DONE
      tick(0, 1, 1);
      chk("done_ld", 32'({cout, we, re, addr, elem}), 0);

      // freeze 5 cycles inside M2
      for (int k = 1; k <= N + 6; k++) begin
         if (k >= 15 && k < 20) begin
            tick(0, 0, 0);
            chk("frz_elem", 32'(elem), 2);
         end else begin
            tick(0, 0, 1);
         end
         if (k == N + 5) chk("frz_cout_early", 32'(cout), 0);
         if (k == N + 6) chk("frz_cout", 32'(cout), 1);
      end

      // rst in DONE
      tick(1, 0, 1);
      chk("done_rst", 32'(cout), 0);

      // abort mid-M3 then restart
      for (int k = 0; k < 23; k++) tick(0, 0, 1);
      chk("pre_abort_elem", 32'(elem), 3);
      tick(0, 1, 1);
      chk("abort", 32'({we, re, addr, elem}), 0);
      for (int k = 1; k <= N + 1; k++) tick(0, 0, 1);
      chk("restart_cout", 32'(cout), 1);

      // random traffic
      tick(1, 0, 0);
      for (int k = 0; k < 4000; k++) begin
         logic r, l, e;
         r = ($urandom_range(0, 199) == 0);
         l = ($urandom_range(0, 99) < 2);
         e = ($urandom_range(0, 99) < 80);
         tick(r, l, e);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
